// File: rtl/uart_baud_pkg.sv
// Shared constants and elaboration-time helpers for the UART baud-rate generator.
package uart_baud_pkg;

  localparam int ACC_W = 32;
  localparam int OVS   = 16;
  localparam int OVS_W = $clog2(OVS);

  typedef logic [OVS_W-1:0] ovs_cnt_t;
  typedef logic [ACC_W-1:0] acc_t;

  // Clocks per 16x tick, rounded to nearest and never below one.
  function automatic int calc_div16(input longint clock_freq, input longint baud_rate);
    longint div;
    div = (clock_freq + longint'(8) * baud_rate) / (longint'(16) * baud_rate);
    if (div < longint'(1)) div = longint'(1);
    return int'(div);
  endfunction

  // Phase increment for the 32-bit accumulator; saturates when the 16x rate equals the clock.
  function automatic acc_t calc_inc(input longint clock_freq, input longint baud_rate);
    longint num;
    longint inc;
    num = (longint'(16) * baud_rate) << ACC_W;
    inc = (num + clock_freq / longint'(2)) / clock_freq;
    if (inc > longint'(64'h0000_0000_FFFF_FFFF)) inc = longint'(64'h0000_0000_FFFF_FFFF);
    if (inc < longint'(1)) inc = longint'(1);
    return acc_t'(inc);
  endfunction

endpackage

// File: rtl/uart_tick_div16.sv
// Divide-by-16 stage: turns the 16x oversampling strobe into the 1x bit strobe.
module uart_tick_div16
  import uart_baud_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic tick_in,
  output logic tick_out
);

  ovs_cnt_t r_ovs_cnt;
  logic     r_tick_out;
  logic     w_last;

  assign w_last = (r_ovs_cnt == ovs_cnt_t'(OVS - 1));

  // tick_in is the pre-register wrap strobe, so this registered output lines up with baud_tick_16x.
  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments; reset is synchronous, so it lives inside the clocked branch.
    if (!rst) begin
      r_ovs_cnt  <= '0;
      r_tick_out <= 1'b0;
    end else begin
      r_tick_out <= tick_in & w_last;
      if (tick_in) r_ovs_cnt <= r_ovs_cnt + 1'b1;
    end
  end

  assign tick_out = r_tick_out;

endmodule

// File: rtl/uart_baud_gen.sv
// UART baud-rate tick generator (16x and 1x strobes).
// Define UART_BAUD_FRAC_EN to replace the integer prescaler with a 32-bit phase accumulator.
module uart_baud_gen
  import uart_baud_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic clk,
  input  logic rst,
  output logic baud_tick_16x,
  output logic baud_tick
);

  localparam int DIV16 = calc_div16(longint'(CLOCK_FREQ), longint'(BAUD_RATE));

  generate
    if (longint'(16) * longint'(BAUD_RATE) > longint'(CLOCK_FREQ)) begin : g_rate_check
      $error("uart_baud_gen: 16*BAUD_RATE exceeds CLOCK_FREQ");
    end
  endgenerate

  logic w_wrap;
  logic r_tick_16x;

`ifdef UART_BAUD_FRAC_EN
  localparam acc_t INC = calc_inc(longint'(CLOCK_FREQ), longint'(BAUD_RATE));

  acc_t           r_acc;
  logic [ACC_W:0] w_sum;

  // The carry out of the accumulator is the 16x event.
  assign w_sum  = {1'b0, r_acc} + {1'b0, INC};
  assign w_wrap = w_sum[ACC_W];

  always_ff @(posedge clk) begin
    if (!rst) r_acc <= '0;
    else      r_acc <= w_sum[ACC_W-1:0];
  end
`else
  localparam int              CNT_W   = (DIV16 > 1) ? $clog2(DIV16) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV16 - 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_wrap = (r_cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst)        r_cnt <= '0;
    else if (w_wrap) r_cnt <= '0;
    else             r_cnt <= r_cnt + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst) r_tick_16x <= 1'b0;
    else      r_tick_16x <= w_wrap;
  end

  uart_tick_div16 u_div16 (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (w_wrap),
    .tick_out (baud_tick)
  );

  assign baud_tick_16x = r_tick_16x;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: three integer configurations, or the fractional mode when UART_BAUD_FRAC_EN is defined.
module tb_uart_baud_gen;

  logic clk;
  logic rst_a, rst_b, rst_c;
  logic t16_a, bt_a, t16_b, bt_b, t16_c, bt_c;

  int checks;
  int failures;

  // DIV16 = 10
  uart_baud_gen #(.CLOCK_FREQ(1_600_000), .BAUD_RATE(10_000)) dut_a (
    .clk(clk), .rst(rst_a), .baud_tick_16x(t16_a), .baud_tick(bt_a)
  );
  // DIV16 = 1
  uart_baud_gen #(.CLOCK_FREQ(16), .BAUD_RATE(1)) dut_b (
    .clk(clk), .rst(rst_b), .baud_tick_16x(t16_b), .baud_tick(bt_b)
  );
  // DIV16 = 27
  uart_baud_gen #(.CLOCK_FREQ(50_000_000), .BAUD_RATE(115_200)) dut_c (
    .clk(clk), .rst(rst_c), .baud_tick_16x(t16_c), .baud_tick(bt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold one DUT in reset for 10 cycles; the next rising edge is edge 1.
  task automatic hold_reset(input int sel);
    case (sel)
      0: rst_a = 1'b0;
      1: rst_b = 1'b0;
      default: rst_c = 1'b0;
    endcase
    repeat (10) step();
    case (sel)
      0: rst_a = 1'b1;
      1: rst_b = 1'b1;
      default: rst_c = 1'b1;
    endcase
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    repeat (10) step();
    checks++; if (t16_a !== 1'b0) begin failures++; $display("FAIL reset_t16_a got=%b exp=0", t16_a); end
    checks++; if (bt_a  !== 1'b0) begin failures++; $display("FAIL reset_bt_a got=%b exp=0", bt_a); end
    checks++; if (t16_b !== 1'b0) begin failures++; $display("FAIL reset_t16_b got=%b exp=0", t16_b); end
    checks++; if (bt_b  !== 1'b0) begin failures++; $display("FAIL reset_bt_b got=%b exp=0", bt_b); end
    checks++; if (t16_c !== 1'b0) begin failures++; $display("FAIL reset_t16_c got=%b exp=0", t16_c); end
    checks++; if (bt_c  !== 1'b0) begin failures++; $display("FAIL reset_bt_c got=%b exp=0", bt_c); end
  endtask

`ifndef UART_BAUD_FRAC_EN
  // Edge-by-edge pattern for DIV16 = 10 plus the spacing of 10 consecutive baud ticks.
  task automatic test_integer_period();
    int   last_bt;
    int   n_int;
    logic exp16, expb;
    last_bt = 0;
    n_int   = 0;
    hold_reset(0);
    for (int k = 1; k <= 1760; k++) begin
      step();
      exp16 = ((k % 10) == 0);
      expb  = ((k % 160) == 0);
      checks++; if (t16_a !== exp16) begin failures++; $display("FAIL int_t16 edge=%0d got=%b exp=%b", k, t16_a, exp16); end
      checks++; if (bt_a !== expb) begin failures++; $display("FAIL int_bt edge=%0d got=%b exp=%b", k, bt_a, expb); end
      if (bt_a === 1'b1) begin
        if (last_bt != 0) begin
          n_int++;
          checks++; if (k - last_bt != 160) begin failures++; $display("FAIL int_bt_interval edge=%0d got=%0d exp=160", k, k - last_bt); end
        end
        last_bt = k;
      end
    end
    checks++; if (n_int != 10) begin failures++; $display("FAIL int_bt_interval_count got=%0d exp=10", n_int); end
  endtask

  // Baud tick is single-cycle, coincident with a 16x tick, and preceded by exactly 16 of them.
  task automatic test_coincidence();
    int   n16;
    int   n_bt;
    logic prev_bt;
    n16     = 0;
    n_bt    = 0;
    prev_bt = 1'b0;
    hold_reset(0);
    for (int k = 1; k <= 1600; k++) begin
      step();
      if (t16_a === 1'b1) n16++;
      if (bt_a === 1'b1) begin
        n_bt++;
        checks++; if (t16_a !== 1'b1) begin failures++; $display("FAIL coinc_t16 edge=%0d got=%b exp=1", k, t16_a); end
        checks++; if (prev_bt !== 1'b0) begin failures++; $display("FAIL coinc_width edge=%0d prev=%b exp=0", k, prev_bt); end
        checks++; if (n16 != 16) begin failures++; $display("FAIL coinc_count edge=%0d got=%0d exp=16", k, n16); end
        n16 = 0;
      end
      prev_bt = bt_a;
    end
    checks++; if (n_bt != 10) begin failures++; $display("FAIL coinc_bt_total got=%0d exp=10", n_bt); end
  endtask

  // Reset asserted for 3 cycles after edge 85; the phase restarts from zero on release.
  task automatic test_reset_mid_period();
    logic exp16, expb;
    hold_reset(0);
    repeat (85) step();
    rst_a = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (t16_a !== 1'b0) begin failures++; $display("FAIL mid_rst_t16 cyc=%0d got=%b exp=0", k, t16_a); end
      checks++; if (bt_a !== 1'b0) begin failures++; $display("FAIL mid_rst_bt cyc=%0d got=%b exp=0", k, bt_a); end
    end
    rst_a = 1'b1;
    for (int k = 1; k <= 320; k++) begin
      step();
      exp16 = ((k % 10) == 0);
      expb  = ((k % 160) == 0);
      checks++; if (t16_a !== exp16) begin failures++; $display("FAIL mid_post_t16 edge=%0d got=%b exp=%b", k, t16_a, exp16); end
      checks++; if (bt_a !== expb) begin failures++; $display("FAIL mid_post_bt edge=%0d got=%b exp=%b", k, bt_a, expb); end
    end
  endtask

  // DIV16 = 1: 16x tick continuously high, baud tick every 16th edge.
  task automatic test_div1();
    logic expb;
    hold_reset(1);
    for (int k = 1; k <= 64; k++) begin
      step();
      expb = ((k % 16) == 0);
      checks++; if (t16_b !== 1'b1) begin failures++; $display("FAIL div1_t16 edge=%0d got=%b exp=1", k, t16_b); end
      checks++; if (bt_b !== expb) begin failures++; $display("FAIL div1_bt edge=%0d got=%b exp=%b", k, bt_b, expb); end
    end
  endtask

  // 50 MHz / 115200: DIV16 = 27, baud period 432.
  task automatic test_default_rate();
    logic exp16, expb;
    hold_reset(2);
    for (int k = 1; k <= 1296; k++) begin
      step();
      exp16 = ((k % 27) == 0);
      expb  = ((k % 432) == 0);
      checks++; if (t16_c !== exp16) begin failures++; $display("FAIL rate_t16 edge=%0d got=%b exp=%b", k, t16_c, exp16); end
      checks++; if (bt_c !== expb) begin failures++; $display("FAIL rate_bt edge=%0d got=%b exp=%b", k, bt_c, expb); end
    end
  endtask
`else
  // INC = 158329674: intervals of 27 or 28 cycles, 1843.2 pulses expected in 50_000 cycles.
  task automatic test_frac();
    int last16;
    int n16;
    int n16_since_bt;
    last16       = 0;
    n16          = 0;
    n16_since_bt = 0;
    hold_reset(2);
    for (int k = 1; k <= 50_000; k++) begin
      step();
      if (t16_c === 1'b1) begin
        n16++;
        n16_since_bt++;
        checks++;
        if ((k - last16) < 27 || (k - last16) > 28) begin
          failures++; $display("FAIL frac_interval edge=%0d got=%0d exp=27..28", k, k - last16);
        end
        last16 = k;
      end
      if (bt_c === 1'b1) begin
        checks++; if (t16_c !== 1'b1) begin failures++; $display("FAIL frac_coinc edge=%0d got=%b exp=1", k, t16_c); end
        checks++; if (n16_since_bt != 16) begin failures++; $display("FAIL frac_ovs_count edge=%0d got=%0d exp=16", k, n16_since_bt); end
        n16_since_bt = 0;
      end
    end
    checks++;
    if (n16 < 1842 || n16 > 1844) begin
      failures++; $display("FAIL frac_total got=%0d exp=1843+-1", n16);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst_a    = 1'b0;
    rst_b    = 1'b0;
    rst_c    = 1'b0;
    test_reset();
`ifndef UART_BAUD_FRAC_EN
    test_integer_period();
    test_coincidence();
    test_reset_mid_period();
    test_div1();
    test_default_rate();
`else
    test_frac();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
